// File: rtl/stb_pkg.sv
// Shared widths, the pending-store entry record and its address-match helper
// for the store buffer and its CAM.
package stb_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } stb_entry_t;

    // A slot only matches while it holds a store that has not yet been drained.
    function automatic logic entry_match(input stb_entry_t e, input logic [ADDR_W-1:0] a);
        return e.valid && (e.addr == a);
    endfunction

    function automatic stb_entry_t make_entry(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        stb_entry_t e;
        e.valid = 1'b1;
        e.addr  = a;
        e.data  = d;
        return e;
    endfunction

endpackage

// File: rtl/store_buffer_if.sv
// CPU-side and data-memory-side signals of the store buffer.
// The slave modport is the buffer; the master modport is the datapath plus the memory.
interface store_buffer_if;
    import stb_pkg::*;

    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_we;
    logic              cpu_re;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_stall;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wd;
    logic              mem_we;
    logic              mem_re;
    logic [DATA_W-1:0] mem_rd;
    logic              stb_empty;
    logic              stb_full;

    modport slave (
        input  cpu_addr, cpu_wdata, cpu_we, cpu_re, mem_rd,
        output cpu_rdata, cpu_stall, mem_addr, mem_wd, mem_we, mem_re, stb_empty, stb_full
    );

    modport master (
        output cpu_addr, cpu_wdata, cpu_we, cpu_re, mem_rd,
        input  cpu_rdata, cpu_stall, mem_addr, mem_wd, mem_we, mem_re, stb_empty, stb_full
    );

endinterface

// File: rtl/stb_cam.sv
// Parallel address compare of a load against every valid pending store,
// returning a hit flag and the data of the youngest matching store.
module stb_cam
    import stb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  stb_entry_t                 ent_i [DEPTH],
    input  logic [$clog2(DEPTH)-1:0]   head_i,
    input  logic [ADDR_W-1:0]          addr_i,
    output logic                       hit_o,
    output logic [DATA_W-1:0]          data_o
);

    localparam int PTR_W = $clog2(DEPTH);

    // Walk oldest to youngest from the head so a later match overrides an earlier one.
    always_comb begin
        logic [PTR_W-1:0] idx;
        logic             m;
        hit_o  = 1'b0;
        data_o = {DATA_W{1'b0}};
        idx    = head_i;
        m      = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            idx    = head_i + PTR_W'(i);
            m      = entry_match(ent_i[idx], addr_i);
            hit_o  = m ? 1'b1 : hit_o;
            data_o = m ? ent_i[idx].data : data_o;
        end
    end

endmodule

// File: rtl/store_buffer.sv
// FIFO store buffer between the datapath and a single-port data memory.
// Define STB_FWD_EN to return the youngest matching pending store to a load.
module store_buffer
    import stb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    store_buffer_if.slave   bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

`ifdef STB_FWD_EN
    localparam logic FWD_EN = 1'b1;
`else
    localparam logic FWD_EN = 1'b0;
`endif

    stb_entry_t        ent_q [DEPTH];
    stb_entry_t        ent_d [DEPTH];
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic              cam_hit_s;
    logic [DATA_W-1:0] cam_data_s;
    logic              full_s, empty_s;
    logic              store_s, load_s, mem_load_s;
    logic              fwd_hit_s, blk_hit_s;
    logic              rd_s, enq_s, deq_s, stall_s;
    logic [ADDR_W-1:0] mem_addr_s;
    logic [DATA_W-1:0] mem_wd_s, rdata_s;

    // Without forwarding the CAM still detects loads that must wait for a drain.
    stb_cam #(.DEPTH(DEPTH)) u_cam (
        .ent_i  (ent_q),
        .head_i (head_q),
        .addr_i (bus.cpu_addr),
        .hit_o  (cam_hit_s),
        .data_o (cam_data_s)
    );

    // Port arbitration: a memory-bound load takes the port unless the buffer is full;
    // stores only enqueue, so the head drains on any cycle that does not accept one.
    always_comb begin
        full_s     = (count_q == CNT_MAX);
        empty_s    = (count_q == {CNT_W{1'b0}});
        store_s    = bus.cpu_we;
        load_s     = bus.cpu_re & ~bus.cpu_we;
        fwd_hit_s  = load_s & cam_hit_s & FWD_EN;
        blk_hit_s  = load_s & cam_hit_s & ~FWD_EN;
        mem_load_s = load_s & ~cam_hit_s;
        rd_s       = mem_load_s & ~full_s;
        enq_s      = store_s & ~full_s;
        deq_s      = ~empty_s & ~rd_s & ~enq_s;
        stall_s    = (store_s & full_s) | (mem_load_s & full_s) | blk_hit_s;
    end

    // Memory port and load-result muxing; unused port fields read as zero.
    always_comb begin
        mem_addr_s = {ADDR_W{1'b0}};
        mem_wd_s   = {DATA_W{1'b0}};
        rdata_s    = {DATA_W{1'b0}};
        if (rd_s) begin
            mem_addr_s = bus.cpu_addr;
            rdata_s    = bus.mem_rd;
        end else if (deq_s) begin
            mem_addr_s = ent_q[head_q].addr;
            mem_wd_s   = ent_q[head_q].data;
        end else begin
            mem_addr_s = {ADDR_W{1'b0}};
        end
        if (fwd_hit_s) begin
            rdata_s = cam_data_s;
        end else begin
            rdata_s = rdata_s;
        end
    end

    // Next FIFO state: dequeue frees the head slot, enqueue fills the tail slot.
    always_comb begin
        ent_d  = ent_q;
        head_d = head_q;
        tail_d = tail_q;
        if (deq_s) begin
            ent_d[head_q].valid = 1'b0;
            head_d              = head_q + PTR_ONE;
        end else begin
            head_d = head_q;
        end
        if (enq_s) begin
            ent_d[tail_q] = make_entry(bus.cpu_addr, bus.cpu_wdata);
            tail_d        = tail_q + PTR_ONE;
        end else begin
            tail_d = tail_q;
        end
        case ({enq_s, deq_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // State registers; reset discards every pending store immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= {($bits(stb_entry_t)){1'b0}};
            end
            head_q  <= {PTR_W{1'b0}};
            tail_q  <= {PTR_W{1'b0}};
            count_q <= {CNT_W{1'b0}};
        end else begin
            ent_q   <= ent_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign bus.cpu_rdata = rdata_s;
    assign bus.cpu_stall = stall_s;
    assign bus.mem_addr  = mem_addr_s;
    assign bus.mem_wd    = mem_wd_s;
    assign bus.mem_we    = deq_s;
    assign bus.mem_re    = rd_s;
    assign bus.stb_empty = empty_s;
    assign bus.stb_full  = full_s;

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios plus random traffic
// against a queue-based reference model and a behavioural data memory.
module tb_store_buffer;

    localparam int DEPTH = 4;
`ifdef STB_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct {
        logic [15:0] a;
        logic [15:0] d;
    } ref_ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    store_buffer_if bus();

    logic [15:0] mem    [0:65535];
    logic [15:0] refmem [0:65535];
    ref_ent_t    q [$];
    int vec  = 0;
    int miss = 0;

    always #5 clk = ~clk;

    assign bus.mem_rd = mem[bus.mem_addr];

    store_buffer #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vec++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock of traffic: drive, check against the model, then commit both memories.
    task automatic do_cycle(input logic we, input logic re, input logic [15:0] addr,
                            input logic [15:0] wdata, output logic stalled);
        logic e_we, e_re, e_stall, drain, push, hit, full;
        logic [15:0] e_addr, e_wd, e_rd, hd;
        logic        s_we;
        logic [15:0] s_addr, s_wd;
        @(negedge clk);
        bus.cpu_we = we; bus.cpu_re = re; bus.cpu_addr = addr; bus.cpu_wdata = wdata;
        #1;
        e_we = 1'b0; e_re = 1'b0; e_stall = 1'b0; drain = 1'b0; push = 1'b0; hit = 1'b0;
        e_addr = 16'h0000; e_wd = 16'h0000; e_rd = 16'h0000; hd = 16'h0000;
        full = (q.size() == DEPTH);
        chk("stb_empty", 16'(bus.stb_empty), 16'(q.size() == 0));
        chk("stb_full",  16'(bus.stb_full),  16'(full));
        if (we) begin
            if (!full) push = 1'b1;
            else begin e_stall = 1'b1; drain = 1'b1; end
        end else if (re) begin
            foreach (q[k]) if (q[k].a == addr) begin hit = 1'b1; hd = q[k].d; end
            if (hit && FWD) begin
                e_rd = hd; drain = (q.size() != 0);
            end else if (hit || full) begin
                e_stall = 1'b1; drain = 1'b1;
            end else begin
                e_re = 1'b1; e_addr = addr; e_rd = refmem[addr];
            end
        end else begin
            drain = (q.size() != 0);
        end
        if (drain) begin e_we = 1'b1; e_addr = q[0].a; e_wd = q[0].d; end
        chk("cpu_stall", 16'(bus.cpu_stall), 16'(e_stall));
        chk("cpu_rdata", bus.cpu_rdata, e_rd);
        chk("mem_we",    16'(bus.mem_we), 16'(e_we));
        chk("mem_re",    16'(bus.mem_re), 16'(e_re));
        chk("mem_addr",  bus.mem_addr, e_addr);
        chk("mem_wd",    bus.mem_wd, e_wd);
        s_we = bus.mem_we; s_addr = bus.mem_addr; s_wd = bus.mem_wd;
        @(posedge clk);
        if (s_we) mem[s_addr] = s_wd;
        if (drain) begin refmem[q[0].a] = q[0].d; void'(q.pop_front()); end
        if (push) q.push_back('{a: addr, d: wdata});
        stalled = e_stall;
    endtask

    // Datapath holds a stalled request until accepted, within a bounded number of cycles.
    task automatic hold_req(input logic we, input logic re, input logic [15:0] addr,
                            input logic [15:0] wdata, output logic first_stall);
        logic st;
        int   n = 0;
        do_cycle(we, re, addr, wdata, st);
        first_stall = st;
        n = 1;
        while (st && n < 16) begin
            do_cycle(we, re, addr, wdata, st);
            n++;
        end
        chk("req_accepted", 16'(st), 16'h0000);
    endtask

    task automatic idle(input int n);
        logic st;
        for (int i = 0; i < n; i++) do_cycle(1'b0, 1'b0, 16'h0000, 16'h0000, st);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic st;
        logic fs;
        int   bad;
        for (int i = 0; i < 65536; i++) begin
            mem[i]    = 16'(i) ^ 16'h5A5A;
            refmem[i] = 16'(i) ^ 16'h5A5A;
        end
        bus.cpu_we = 1'b0; bus.cpu_re = 1'b0; bus.cpu_addr = 16'h0000; bus.cpu_wdata = 16'h0000;
        #2;
        chk("rst_empty", 16'(bus.stb_empty), 16'h0001);
        chk("rst_full",  16'(bus.stb_full),  16'h0000);
        chk("rst_stall", 16'(bus.cpu_stall), 16'h0000);
        chk("rst_mem_we", 16'(bus.mem_we), 16'h0000);
        chk("rst_mem_re", 16'(bus.mem_re), 16'h0000);
        chk("rst_rdata", bus.cpu_rdata, 16'h0000);
        @(negedge clk);
        rst = 1'b0;

        // Reset in the middle of operation discards three queued stores.
        for (int i = 0; i < 3; i++) hold_req(1'b1, 1'b0, 16'h0300 + 16'(i), 16'h1000 + 16'(i), fs);
        @(negedge clk);
        bus.cpu_we = 1'b0; bus.cpu_re = 1'b0;
        rst = 1'b1;
        #1;
        q.delete();
        chk("midrst_empty", 16'(bus.stb_empty), 16'h0001);
        chk("midrst_mem_we", 16'(bus.mem_we), 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        idle(3);
        chk("midrst_mem_untouched", mem[16'h0300], 16'h0300 ^ 16'h5A5A);

        // Fill: the fifth back-to-back store stalls; drains keep address order.
        for (int i = 0; i < 5; i++) begin
            hold_req(1'b1, 1'b0, 16'h0100 + 16'(i), 16'hC000 + 16'(i), fs);
            chk("fill_stall", 16'(fs), 16'(i == 4));
        end
        idle(6);

        // Two stores to one address followed by a load of it.
        hold_req(1'b1, 1'b0, 16'h0010, 16'hAAAA, fs);
        hold_req(1'b1, 1'b0, 16'h0010, 16'hBBBB, fs);
        do_cycle(1'b0, 1'b1, 16'h0010, 16'h0000, st);
        chk("fwd_first_stall", 16'(st), 16'(!FWD));
        if (st) hold_req(1'b0, 1'b1, 16'h0010, 16'h0000, fs);
        chk("fwd_rdata", bus.cpu_rdata, 16'hBBBB);
        idle(4);

        // Full buffer plus a non-matching load: drain first, then read memory.
        for (int i = 0; i < 4; i++) hold_req(1'b1, 1'b0, 16'h0200 + 16'(i), 16'hD000 + 16'(i), fs);
        do_cycle(1'b0, 1'b1, 16'h0020, 16'h0000, st);
        chk("arb_c1_stall", 16'(st), 16'h0001);
        do_cycle(1'b0, 1'b1, 16'h0020, 16'h0000, st);
        chk("arb_c2_stall", 16'(st), 16'h0000);
        idle(5);

        // Store/drain traffic that wraps the pointers several times.
        for (int i = 0; i < 10; i++) begin
            hold_req(1'b1, 1'b0, 16'h0400 + 16'(i), 16'(i * 7 + 3), fs);
            idle(1);
        end

        // Random mix of stores, loads, both, and idle on a small address window.
        for (int i = 0; i < 400; i++) begin
            int r;
            r = $urandom_range(0, 4);
            do_cycle(r == 0 || r == 1 || r == 4, r == 2 || r == 4,
                     16'h0040 + 16'($urandom_range(0, 7)), 16'($urandom), st);
        end
        idle(6);

        bad = 0;
        for (int i = 0; i < 65536; i++) if (mem[i] !== refmem[i]) bad++;
        chk("mem_image_diffs", 16'(bad), 16'h0000);
        chk("final_empty", 16'(bus.stb_empty), 16'h0001);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of pending-store entries (power of 2, 2..16).
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have cpu_addr, input, 16, load/store address from datapath.
REQ-005 SHALL have cpu_wdata, input, 16, store data.
REQ-006 SHALL have cpu_we / cpu_re, input, 1 each, store / load request.
REQ-007 SHALL have cpu_rdata, output, 16, load result (combinational).
REQ-008 SHALL have cpu_stall, output, 1, request not accepted this cycle; datapath holds.
REQ-009 SHALL have mem_addr, mem_wd, output, 16 each, driven to the data memory A/WD.
REQ-010 SHALL have mem_we / mem_re, output, 1 each, driven to the data memory WE/RE.
REQ-011 SHALL have mem_rd, input, 16, data memory RD (combinational read).
REQ-012 SHALL have stb_empty / stb_full, output, 1 each, occupancy flags.

Function
REQ-013 SHALL hold up to DEPTH {addr,data} entries in FIFO order; head/tail pointers wrap modulo DEPTH; count 0..DEPTH.
REQ-014 SHALL accept a store (enqueue at tail) when cpu_we=1 and count<DEPTH; cpu_stall=0.
REQ-015 SHALL assert cpu_stall and not enqueue when cpu_we=1 and count==DEPTH; no bypass of a same-cycle drain.
REQ-016 SHALL treat cpu_we=1 with cpu_re=1 as store only; cpu_rdata=0.
REQ-017 SHALL use one memory port per cycle: mem_we and mem_re never both 1.
REQ-018 Port arbitration: load needing memory wins if count<DEPTH; else drain head (mem_we=1, mem_addr/mem_wd=head entry, dequeue at edge).
REQ-019 SHALL, on count==DEPTH with a memory-bound load, drain and assert cpu_stall for that load.
REQ-020 Memory-bound load: mem_re=1, mem_we=0, mem_addr=cpu_addr, cpu_rdata=mem_rd same cycle (zero latency).
REQ-021 SHALL output mem_we=0, mem_re=0, cpu_rdata=0 when idle; mem_addr/mem_wd=0 when port unused.
REQ-022 Simultaneous enqueue and dequeue SHALL leave count unchanged.
REQ-023 Address match compares all 16 bits against every valid entry.
REQ-024 stb_empty=(count==0); stb_full=(count==DEPTH); both combinational from registered count.

Reset
REQ-025 On rst: count=0, head=tail=0, all entries invalid, pending stores discarded, regardless of clock.
REQ-026 Outputs during/after reset: stb_empty=1, stb_full=0, cpu_stall=0, mem_we=0, mem_re=0, cpu_rdata=0.

Configuration
REQ-027 Macro STB_FWD_EN SHALL enable load forwarding.
REQ-028 With STB_FWD_EN: load matching any entry returns youngest matching entry data, cpu_stall=0, no memory read; head drain proceeds in the same cycle.
REQ-029 Without STB_FWD_EN: load matching any entry asserts cpu_stall and drains each cycle until no match, then reads memory.

Structure
REQ-030 Package stb_pkg SHALL hold ADDR_W=16, DATA_W=16, entry typedef {valid, addr, data}.
REQ-031 Sub-module stb_cam SHALL perform the parallel match and youngest-hit select (hit flag, data); instantiated only under STB_FWD_EN and for the stall match otherwise.

Verification
REQ-032 Reset mid-operation: 3 stores queued, assert rst -> count=0, stb_empty=1, no further mem_we.
REQ-033 Fill: 5 back-to-back stores, DEPTH=4, no loads -> 5th sees cpu_stall=1, mem_we sequence drains addr order intact.
REQ-034 Forward (STB_FWD_EN): store 0x0010<-0xAAAA, store 0x0010<-0xBBBB, load 0x0010 -> cpu_rdata=0xBBBB, mem_re=0.
REQ-035 No forward (macro off): same stimulus -> cpu_stall=1 until both drained, then cpu_rdata=0xBBBB from memory.
REQ-036 Arbitration: count=4, load 0x0020 (no match) -> cycle 1 mem_we=1, cpu_stall=1; cycle 2 mem_re=1, cpu_rdata=mem[0x0020].
REQ-037 Wrap: 10 store/drain cycles with DEPTH=4 -> pointers wrap, memory contents equal reference model.
